if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register. It owns the program counter and drives a request/ready instruction-memory interface. It applies redirects (jump, taken branch) and hazard stalls. Each cycle it presents {instruction, PC+4, init, flush} to the IF/ID register's Inst_in, PCIncr_in, init_in and IF_IDFlush inputs.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after boot
INIT_CYCLES, 4, cycles held in BOOT after reset release before the first fetch (1..255)
ADDR_W, 32, PC/address width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
pc_write  in  1  hazard unit: 1 = PC may advance; 0 = hold PC (load-use stall)
branch_taken  in  1  taken-branch redirect request from ID/EX
branch_target  in  ADDR_W  branch target
jump  in  1  jump redirect request
jump_target  in  ADDR_W  jump target
imem_req  out  1  fetch request, held until imem_ready
imem_addr  out  ADDR_W  fetch address, stable while imem_req=1 and imem_ready=0
imem_rdata  in  32  instruction word, valid when imem_ready=1
imem_ready  in  1  memory completes the outstanding request this cycle
inst_out  out  32  fetched instruction (to IF/ID Inst_in)
pc_incr_out  out  ADDR_W  fetch address + 4 (to IF/ID PCIncr_in)
init_out  out  1  1 = inst_out is a valid, on-path instruction (to IF/ID init_in)
if_flush_out  out  1  bubble request to IF/ID (to IF_IDFlush)
pc_out  out  ADDR_W  current PC (debug)

Behaviour:
- Reset (async, active-high):
  - state=BOOT, pc=RESET_PC, boot_cnt=0, pend=0, redir_pc=0.
  - Outputs during reset: imem_req=0, init_out=0, if_flush_out=1, inst_out=0, pc_incr_out=RESET_PC+4.
- Reset asserted mid-operation aborts any outstanding request. The memory side must tolerate a dropped request.
- States:
  - BOOT: imem_req=0, if_flush_out=1. boot_cnt increments each cycle. Move to FETCH when boot_cnt==INIT_CYCLES-1.
  - FETCH: imem_req=1, imem_addr=pc.
  - DRAIN: imem_req=1, imem_addr=pc (the stale address). Entered when a redirect arrives while a request is outstanding.
- Output path is combinational, zero latency; IF/ID provides the register.
  - inst_out=imem_rdata.
  - pc_incr_out=pc+4, modulo 2^ADDR_W (0xFFFF_FFFC wraps to 0).
  - init_out = (state==FETCH) & imem_ready & ~redirect.
  - if_flush_out = ~init_out & pc_write. When pc_write=0, IF/ID holds and no flush is issued.
- redirect = jump | branch_taken. Target = jump ? jump_target : branch_target (jump wins). Bits[1:0] of the target are forced to 0.
- FETCH, PC update priority:
  - redirect & imem_ready: pc<=target. The word returning this cycle is wrong-path: init_out=0, flush.
  - redirect & ~imem_ready: latch redir_pc<=target, go to DRAIN. pc is unchanged so imem_addr stays stable.
  - ~redirect & imem_ready & pc_write: pc<=pc+4.
  - ~redirect & imem_ready & ~pc_write: pc held, and the same address is re-fetched next cycle.
  - ~imem_ready, no redirect: hold, if_flush_out=1 (bubble while memory waits).
- DRAIN:
  - Returning word is discarded (init_out=0).
  - On imem_ready: pc<=redir_pc, go to FETCH.
  - A newer redirect in DRAIN overwrites redir_pc; the last one wins.
  - pc_write is ignored in DRAIN.
- Redirects are honoured regardless of pc_write (a branch flush overrides a stall).
- Redirects during BOOT: ignored.

Optional Feature:
Macro IF_FETCH_PERF_EN.
- Defined: adds outputs perf_fetch_cnt[31:0] and perf_stall_cnt[31:0].
  - perf_fetch_cnt counts cycles with init_out & pc_write.
  - perf_stall_cnt counts FETCH/DRAIN cycles with imem_req & ~imem_ready.
  - Both are reset to 0, wrap at 2^32, and saturate never.
- Undefined: the ports and counters are absent, with no functional change otherwise.

Decomposition:
- Shared package pipe_pkg:
  - fetch-state enum {BOOT, FETCH, DRAIN}
  - constant INST_BYTES=4
  - constant NOP_INST=32'h0
  - ADDR_W default
- One natural sub-module: if_next_pc (combinational target select, alignment and +4 increment). The FSM and registers stay in if_fetch_unit.

Test Plan:
- Boot: release reset with INIT_CYCLES=4 and imem_ready tied 1 -> imem_req first high on cycle 4. First fetch addr=0x0 with init_out=1, then 0x4, 0x8; pc_incr_out=addr+4.
- Stall: pc_write=0 for 2 cycles at pc=0x10, ready=1 -> imem_addr stays 0x10, if_flush_out=0, pc_out=0x10. Resumes at 0x14 after pc_write=1.
- Redirect with ready: branch_taken=1, target=0x100 while fetching 0x20 -> init_out=0, if_flush_out=1 that cycle; next imem_addr=0x100.
- Redirect during wait: jump to 0x200 while 0x30 outstanding (ready=0 for 3 cycles) -> imem_addr holds 0x30. The returned word is discarded, then imem_addr=0x200. A simultaneous branch_taken to 0x300 loses to the jump.
- Wrap/align: pc=0xFFFF_FFFC fetched -> pc_incr_out=0x0, next pc=0x0; jump_target=0x0000_0103 -> imem_addr=0x0000_0100.
- Reset mid-DRAIN: assert reset with a redirect pending -> imem_req drops immediately and pend clears. After release, BOOT repeats and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: fetch-state encoding, instruction size and bubble word.
package pipe_pkg;
   localparam int          ADDR_W_DEF = 32;
   localparam int          INST_BYTES = 4;
   localparam logic [31:0] NOP_INST   = 32'h0;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } fetch_state_e;
endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/ready port between the fetch unit (master) and memory (slave).
interface if_fetch_unit_if #(
   parameter int ADDR_W = 32
);
   // Handshake: master raises imem_req with imem_addr and holds both stable until the
   // slave asserts imem_ready; imem_rdata is valid only in the cycle imem_ready=1.
   // A request may be dropped without completion when the master is reset.
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_rdata;
   logic              imem_ready;

   modport master (output imem_req, output imem_addr, input imem_rdata, input imem_ready);
   modport slave  (input imem_req, input imem_addr, output imem_rdata, output imem_ready);
endinterface

// File: rtl/if_fetch_unit_next_pc.sv
// if_next_pc: redirect target select (jump beats branch), word alignment and sequential PC+4.
module if_next_pc
   import pipe_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic [ADDR_W-1:0] pc_i,
   input  logic              jump_i,
   input  logic [ADDR_W-1:0] jump_target_i,
   input  logic [ADDR_W-1:0] branch_target_i,
   output logic [ADDR_W-1:0] redir_target_o,
   output logic [ADDR_W-1:0] pc_plus4_o
);
   logic [ADDR_W-1:0] sel_target;

   always_comb begin
      sel_target     = jump_i ? jump_target_i : branch_target_i;
      redir_target_o = sel_target & ~ADDR_W'(3);
      // Natural modulo-2^ADDR_W wrap of the last word back to address zero.
      pc_plus4_o     = pc_i + ADDR_W'(INST_BYTES);
   end
endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage feeding the IF/ID register; owns the PC and the imem request.
// Optional performance counters are built when IF_FETCH_PERF_EN is defined.
module if_fetch_unit
   import pipe_pkg::*;
#(
   parameter int                ADDR_W      = ADDR_W_DEF,
   parameter logic [ADDR_W-1:0] RESET_PC    = '0,
   parameter int                INIT_CYCLES = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 pc_write,
   input  logic                 branch_taken,
   input  logic [ADDR_W-1:0]    branch_target,
   input  logic                 jump,
   input  logic [ADDR_W-1:0]    jump_target,
   if_fetch_unit_if.master      imem,
   output logic [31:0]          inst_out,
   output logic [ADDR_W-1:0]    pc_incr_out,
   output logic                 init_out,
   output logic                 if_flush_out,
   output logic [ADDR_W-1:0]    pc_out,
`ifdef IF_FETCH_PERF_EN
   output logic [31:0]          perf_fetch_cnt,
   output logic [31:0]          perf_stall_cnt,
`endif
   output fetch_state_e         fetch_state_dbg
);
   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] redir_pc_q, redir_pc_d;
   logic [7:0]        boot_cnt_q, boot_cnt_d;
   logic              pend_q, pend_d;

   logic              redirect;
   logic              req_c;
   logic              init_c;
   logic [ADDR_W-1:0] redir_target;
   logic [ADDR_W-1:0] pc_plus4;

   if_next_pc #(.ADDR_W(ADDR_W)) u_next_pc (
      .pc_i            (pc_q),
      .jump_i          (jump),
      .jump_target_i   (jump_target),
      .branch_target_i (branch_target),
      .redir_target_o  (redir_target),
      .pc_plus4_o      (pc_plus4)
   );

   assign redirect = jump | branch_taken;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= BOOT;
         pc_q       <= RESET_PC;
         redir_pc_q <= '0;
         boot_cnt_q <= '0;
         pend_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         redir_pc_q <= redir_pc_d;
         boot_cnt_q <= boot_cnt_d;
         pend_q     <= pend_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      redir_pc_d = redir_pc_q;
      boot_cnt_d = boot_cnt_q;
      pend_d     = pend_q;
      req_c      = 1'b0;
      init_c     = 1'b0;
      unique case (state_q)
         BOOT: begin
            boot_cnt_d = boot_cnt_q + 8'd1;
            if (boot_cnt_q == 8'(INIT_CYCLES - 1)) state_d = FETCH;
         end
         FETCH: begin
            req_c  = 1'b1;
            init_c = imem.imem_ready & ~redirect;
            if (redirect && imem.imem_ready) begin
               pc_d = redir_target;
            end else if (redirect) begin
               // Keep pc (and so imem_addr) stable until the stale request completes.
               redir_pc_d = redir_target;
               pend_d     = 1'b1;
               state_d    = DRAIN;
            end else if (imem.imem_ready && pc_write) begin
               pc_d = pc_plus4;
            end
         end
         DRAIN: begin
            req_c = 1'b1;
            if (redirect) redir_pc_d = redir_target;
            if (imem.imem_ready && pend_q) begin
               pc_d    = redirect ? redir_target : redir_pc_q;
               pend_d  = 1'b0;
               state_d = FETCH;
            end
         end
         default: state_d = BOOT;
      endcase
   end

   assign imem.imem_req  = req_c;
   assign imem.imem_addr = pc_q;
   assign init_out       = init_c;
   assign if_flush_out   = (state_q == BOOT) ? 1'b1 : (~init_c & pc_write);
   assign inst_out       = (state_q == BOOT) ? NOP_INST : imem.imem_rdata;
   assign pc_incr_out    = pc_plus4;
   assign pc_out         = pc_q;
   assign fetch_state_dbg = state_q;

`ifdef IF_FETCH_PERF_EN
   logic [31:0] fetch_cnt_q, fetch_cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      fetch_cnt_d = fetch_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (init_c && pc_write)          fetch_cnt_d = fetch_cnt_q + 32'd1;
      if (req_c && !imem.imem_ready)   stall_cnt_d = stall_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         fetch_cnt_q <= fetch_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign perf_fetch_cnt = fetch_cnt_q;
   assign perf_stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios plus randomized traffic
// against a behavioural fetch model.
module tb_if_fetch_unit;
   import pipe_pkg::*;

   localparam int M_BOOT = 0, M_FETCH = 1, M_DRAIN = 2;
   localparam int INIT_N = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        pc_write = 1'b1;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = '0;
   logic        jump = 1'b0;
   logic [31:0] jump_target = '0;
   logic [31:0] inst_out, pc_incr_out, pc_out;
   logic        init_out, if_flush_out;
   fetch_state_e dbg_state;
`ifdef IF_FETCH_PERF_EN
   logic [31:0] perf_fetch_cnt, perf_stall_cnt;
   logic [31:0] m_fetch_cnt, m_stall_cnt;
`endif

   if_fetch_unit_if #(.ADDR_W(32)) imem ();

   if_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0), .INIT_CYCLES(INIT_N)) dut (
      .clk             (clk),
      .reset           (reset),
      .pc_write        (pc_write),
      .branch_taken    (branch_taken),
      .branch_target   (branch_target),
      .jump            (jump),
      .jump_target     (jump_target),
      .imem            (imem),
      .inst_out        (inst_out),
      .pc_incr_out     (pc_incr_out),
      .init_out        (init_out),
      .if_flush_out    (if_flush_out),
      .pc_out          (pc_out),
`ifdef IF_FETCH_PERF_EN
      .perf_fetch_cnt  (perf_fetch_cnt),
      .perf_stall_cnt  (perf_stall_cnt),
`endif
      .fetch_state_dbg (dbg_state)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Behavioural model: fetch mode, PC, pending redirect target.
   int          m_mode;
   int          m_elapsed;
   logic [31:0] m_pc;
   logic [31:0] m_redir;
   logic        e_req, e_init, e_flush;
   logic [31:0] e_addr, e_incr, e_inst;
   logic [31:0] exp_q[$];

   task model_reset();
      m_mode = M_BOOT; m_elapsed = 0; m_pc = 32'h0; m_redir = 32'h0;
`ifdef IF_FETCH_PERF_EN
      m_fetch_cnt = 0; m_stall_cnt = 0;
`endif
   endtask

   task compute_exp();
      logic redir;
      redir   = jump | branch_taken;
      e_req   = (m_mode != M_BOOT);
      e_addr  = m_pc;
      e_incr  = m_pc + 32'd4;
      e_init  = (m_mode == M_FETCH) && imem.imem_ready && !redir;
      e_flush = (m_mode == M_BOOT) ? 1'b1 : (!e_init && pc_write);
      e_inst  = (m_mode == M_BOOT) ? 32'h0 : imem.imem_rdata;
   endtask

   task drive(input logic pw, input logic br, input logic [31:0] bt,
              input logic j, input logic [31:0] jt, input logic rdy, input logic [31:0] rd);
      @(negedge clk);
      pc_write = pw; branch_taken = br; branch_target = bt;
      jump = j; jump_target = jt; imem.imem_ready = rdy; imem.imem_rdata = rd;
      #1;
      compute_exp();
   endtask

   // Advance the model by one clock using the inputs currently applied, then take the edge.
   task tick();
      logic        redir;
      logic [31:0] tgt;
      redir = jump | branch_taken;
      tgt   = (jump ? jump_target : branch_target) & 32'hFFFF_FFFC;
`ifdef IF_FETCH_PERF_EN
      if (e_init && pc_write) m_fetch_cnt = m_fetch_cnt + 1;
      if (m_mode != M_BOOT && !imem.imem_ready) m_stall_cnt = m_stall_cnt + 1;
`endif
      case (m_mode)
         M_BOOT: begin
            m_elapsed = m_elapsed + 1;
            if (m_elapsed == INIT_N) m_mode = M_FETCH;
         end
         M_FETCH: begin
            if (redir && imem.imem_ready) m_pc = tgt;
            else if (redir) begin m_redir = tgt; m_mode = M_DRAIN; end
            else if (imem.imem_ready && pc_write) m_pc = m_pc + 32'd4;
         end
         default: begin
            if (redir) m_redir = tgt;
            if (imem.imem_ready) begin m_pc = m_redir; m_mode = M_FETCH; end
         end
      endcase
      @(posedge clk);
   endtask

   task test_reset();
      reset = 1'b1;
      model_reset();
      @(negedge clk);
      imem.imem_ready = 1'b1; imem.imem_rdata = 32'hDEAD_BEEF;
      jump = 1'b1; jump_target = 32'h80;
      #1;
      checks++; if (imem.imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", imem.imem_req); end
      checks++; if (init_out !== 1'b0) begin errors++; $display("FAIL rst_init: got %b want 0", init_out); end
      checks++; if (if_flush_out !== 1'b1) begin errors++; $display("FAIL rst_flush: got %b want 1", if_flush_out); end
      checks++; if (inst_out !== 32'h0) begin errors++; $display("FAIL rst_inst: got %h want 0", inst_out); end
      checks++; if (pc_incr_out !== 32'h4) begin errors++; $display("FAIL rst_incr: got %h want 4", pc_incr_out); end
      checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h want 0", pc_out); end
      jump = 1'b0;
      reset = 1'b0;
      compute_exp();
      tick();
   endtask

   task test_boot();
      logic [31:0] rd;
      for (int i = 0; i < INIT_N - 1; i++) begin
         drive(1, 0, 0, 0, 0, 1, $urandom);
         checks++; if (imem.imem_req !== 1'b0) begin errors++; $display("FAIL boot_req c%0d: got %b want 0", i, imem.imem_req); end
         checks++; if (if_flush_out !== 1'b1) begin errors++; $display("FAIL boot_flush c%0d: got %b want 1", i, if_flush_out); end
         tick();
      end
      for (int i = 0; i < 3; i++) begin
         rd = $urandom;
         drive(1, 0, 0, 0, 0, 1, rd);
         checks++; if (imem.imem_req !== 1'b1) begin errors++; $display("FAIL boot_fetch_req %0d: got %b want 1", i, imem.imem_req); end
         checks++; if (imem.imem_addr !== 32'(4 * i)) begin errors++; $display("FAIL boot_addr %0d: got %h want %h", i, imem.imem_addr, 32'(4 * i)); end
         checks++; if (init_out !== 1'b1) begin errors++; $display("FAIL boot_init %0d: got %b want 1", i, init_out); end
         checks++; if (pc_incr_out !== 32'(4 * i + 4)) begin errors++; $display("FAIL boot_incr %0d: got %h want %h", i, pc_incr_out, 32'(4 * i + 4)); end
         checks++; if (inst_out !== rd) begin errors++; $display("FAIL boot_inst %0d: got %h want %h", i, inst_out, rd); end
         tick();
      end
   endtask

   task test_stall();
      drive(1, 0, 0, 0, 0, 1, $urandom);
      tick();
      for (int i = 0; i < 2; i++) begin
         drive(0, 0, 0, 0, 0, 1, $urandom);
         checks++; if (imem.imem_addr !== 32'h10) begin errors++; $display("FAIL stall_addr %0d: got %h want 10", i, imem.imem_addr); end
         checks++; if (if_flush_out !== 1'b0) begin errors++; $display("FAIL stall_flush %0d: got %b want 0", i, if_flush_out); end
         checks++; if (pc_out !== 32'h10) begin errors++; $display("FAIL stall_pc %0d: got %h want 10", i, pc_out); end
         tick();
      end
      drive(1, 0, 0, 0, 0, 1, $urandom);
      tick();
      drive(1, 0, 0, 0, 0, 1, $urandom);
      checks++; if (imem.imem_addr !== 32'h14) begin errors++; $display("FAIL stall_resume: got %h want 14", imem.imem_addr); end
      tick();
   endtask

   task test_redirect_ready();
      drive(1, 0, 0, 1, 32'h20, 1, $urandom);
      tick();
      drive(1, 1, 32'h100, 0, 0, 1, $urandom);
      checks++; if (imem.imem_addr !== 32'h20) begin errors++; $display("FAIL rr_addr: got %h want 20", imem.imem_addr); end
      checks++; if (init_out !== 1'b0) begin errors++; $display("FAIL rr_init: got %b want 0", init_out); end
      checks++; if (if_flush_out !== 1'b1) begin errors++; $display("FAIL rr_flush: got %b want 1", if_flush_out); end
      tick();
      drive(1, 0, 0, 0, 0, 1, $urandom);
      checks++; if (imem.imem_addr !== 32'h100) begin errors++; $display("FAIL rr_target: got %h want 100", imem.imem_addr); end
      tick();
   endtask

   task test_redirect_wait();
      drive(1, 0, 0, 1, 32'h30, 1, $urandom);
      tick();
      drive(1, 1, 32'h300, 1, 32'h200, 0, $urandom);
      checks++; if (imem.imem_addr !== 32'h30) begin errors++; $display("FAIL rw_addr0: got %h want 30", imem.imem_addr); end
      checks++; if (if_flush_out !== 1'b1) begin errors++; $display("FAIL rw_flush0: got %b want 1", if_flush_out); end
      tick();
      for (int i = 1; i < 3; i++) begin
         drive($urandom_range(0, 1), 0, 0, 0, 0, 0, $urandom);
         checks++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h30) begin errors++; $display("FAIL rw_hold %0d: got req %b addr %h want 1 30", i, imem.imem_req, imem.imem_addr); end
         tick();
      end
      drive(1, 0, 0, 0, 0, 1, $urandom);
      checks++; if (init_out !== 1'b0) begin errors++; $display("FAIL rw_discard: got %b want 0", init_out); end
      tick();
      drive(1, 0, 0, 0, 0, 1, $urandom);
      checks++; if (imem.imem_addr !== 32'h200) begin errors++; $display("FAIL rw_target: got %h want 200", imem.imem_addr); end
      checks++; if (init_out !== 1'b1) begin errors++; $display("FAIL rw_init: got %b want 1", init_out); end
      tick();
   endtask

   task test_wrap_align();
      drive(1, 0, 0, 1, 32'hFFFF_FFFC, 1, $urandom);
      tick();
      drive(1, 0, 0, 0, 0, 1, $urandom);
      checks++; if (imem.imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr: got %h want fffffffc", imem.imem_addr); end
      checks++; if (pc_incr_out !== 32'h0) begin errors++; $display("FAIL wrap_incr: got %h want 0", pc_incr_out); end
      tick();
      drive(1, 0, 0, 1, 32'h0000_0103, 1, $urandom);
      checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h want 0", pc_out); end
      tick();
      drive(1, 0, 0, 0, 0, 1, $urandom);
      checks++; if (imem.imem_addr !== 32'h100) begin errors++; $display("FAIL align_addr: got %h want 100", imem.imem_addr); end
      tick();
   endtask

   task test_random();
      logic [31:0] a;
      exp_q.delete();
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 9) < 8, $urandom_range(0, 9) == 0, $urandom,
               $urandom_range(0, 12) == 0, $urandom, $urandom_range(0, 9) < 7, $urandom);
         if (e_init && pc_write) exp_q.push_back(e_addr);
         checks++; if (imem.imem_req !== e_req) begin errors++; $display("FAIL rnd_req c%0d: got %b want %b", i, imem.imem_req, e_req); end
         checks++; if (e_req && imem.imem_addr !== e_addr) begin errors++; $display("FAIL rnd_addr c%0d: got %h want %h", i, imem.imem_addr, e_addr); end
         checks++; if (init_out !== e_init) begin errors++; $display("FAIL rnd_init c%0d: got %b want %b", i, init_out, e_init); end
         checks++; if (if_flush_out !== e_flush) begin errors++; $display("FAIL rnd_flush c%0d: got %b want %b", i, if_flush_out, e_flush); end
         checks++; if (pc_incr_out !== e_incr) begin errors++; $display("FAIL rnd_incr c%0d: got %h want %h", i, pc_incr_out, e_incr); end
         checks++; if (inst_out !== e_inst) begin errors++; $display("FAIL rnd_inst c%0d: got %h want %h", i, inst_out, e_inst); end
         if (init_out === 1'b1 && pc_write) begin
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL rnd_sb c%0d: got addr %h want none", i, imem.imem_addr); end
            else begin
               a = exp_q.pop_front();
               if (imem.imem_addr !== a) begin errors++; $display("FAIL rnd_sb c%0d: got %h want %h", i, imem.imem_addr, a); end
            end
         end
         tick();
      end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rnd_sb_left: got %0d want 0", exp_q.size()); end
   endtask

   task test_reset_drain();
      int boot_seen;
      drive(1, 0, 0, 1, 32'h400, 0, $urandom);
      tick();
      drive(1, 0, 0, 0, 0, 0, $urandom);
      checks++; if (imem.imem_req !== 1'b1) begin errors++; $display("FAIL rd_pre_req: got %b want 1", imem.imem_req); end
      reset = 1'b1;
      model_reset();
      #1;
      checks++; if (imem.imem_req !== 1'b0) begin errors++; $display("FAIL rd_req_drop: got %b want 0", imem.imem_req); end
      checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL rd_pc: got %h want 0", pc_out); end
      @(posedge clk);
      @(negedge clk);
      imem.imem_ready = 1'b1;
      reset = 1'b0;
      compute_exp();
      tick();
      boot_seen = 1;
      for (int i = 0; i < 20 && m_mode == M_BOOT; i++) begin
         drive(1, 0, 0, 0, 0, 1, $urandom);
         checks++; if (imem.imem_req !== 1'b0) begin errors++; $display("FAIL rd_boot_req %0d: got %b want 0", i, imem.imem_req); end
         boot_seen++;
         tick();
      end
      checks++; if (boot_seen != INIT_N) begin errors++; $display("FAIL rd_boot_len: got %0d want %0d", boot_seen, INIT_N); end
      drive(1, 0, 0, 0, 0, 1, $urandom);
      checks++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h0) begin errors++; $display("FAIL rd_restart: got req %b addr %h want 1 0", imem.imem_req, imem.imem_addr); end
      checks++; if (init_out !== 1'b1) begin errors++; $display("FAIL rd_restart_init: got %b want 1", init_out); end
      tick();
   endtask

   initial begin
      imem.imem_ready = 1'b0;
      imem.imem_rdata = '0;
      test_reset();
      test_boot();
      test_stall();
      test_redirect_ready();
      test_redirect_wait();
      test_wrap_align();
      test_random();
      test_reset_drain();
`ifdef IF_FETCH_PERF_EN
      @(negedge clk);
      checks++; if (perf_fetch_cnt !== m_fetch_cnt) begin errors++; $display("FAIL perf_fetch: got %0d want %0d", perf_fetch_cnt, m_fetch_cnt); end
      checks++; if (perf_stall_cnt !== m_stall_cnt) begin errors++; $display("FAIL perf_stall: got %0d want %0d", perf_stall_cnt, m_stall_cnt); end
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish want finish");
      $fatal(1, "timeout");
   end
endmodule
